// File: rtl/dmem_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_AW = 6;
  localparam int DMEM_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/dmem_resp_reg.sv
// Per-port read-response register: one-cycle rvalid pulse, rdata held until the next read.
module dmem_resp_reg
  import dmem_pkg::*;
#(
  parameter int DW = DMEM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_en_i,
  input  logic [DW-1:0] rdata_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o
);

  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_en_i;
      if (rd_en_i) begin
        rdata_q <= rdata_i;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing a single-port data memory.
// Optional stall counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_LOCK = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall0_cnt,
  output logic [15:0]   stall1_cnt
`endif
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  arb_state_t state_q;
  logic       last_q;
  logic [7:0] lock_cnt_q;

  logic       gnt0_s, gnt1_s, any_gnt_s, sel_lock_s;
  logic [7:0] beat_cnt_s;

  // Grant decision: ties in IDLE go to the port that was not granted last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (RST) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            gnt0_s = (last_q == P_DBG);
            gnt1_s = (last_q == P_CPU);
          end else begin
            gnt0_s = m0_req;
            gnt1_s = m1_req;
          end
        end
        OWN0:    gnt0_s = m0_req;
        OWN1:    gnt1_s = m1_req;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign any_gnt_s  = gnt0_s | gnt1_s;
  assign sel_lock_s = gnt1_s ? m1_lock : m0_lock;
  assign beat_cnt_s = (state_q == IDLE) ? 8'd1 : (lock_cnt_q + 8'd1);

  // Ownership FSM; reaching MAX_LOCK locked beats forces a release to IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= P_DBG;
      lock_cnt_q <= 8'd0;
    end else if (any_gnt_s) begin
      last_q <= gnt1_s ? P_DBG : P_CPU;
      if (sel_lock_s && (beat_cnt_s != MAX_LOCK_C)) begin
        state_q    <= gnt1_s ? OWN1 : OWN0;
        lock_cnt_q <= beat_cnt_s;
      end else begin
        state_q    <= IDLE;
        lock_cnt_q <= 8'd0;
      end
    end else begin
      last_q     <= last_q;
      state_q    <= IDLE;
      lock_cnt_q <= 8'd0;
    end
  end

  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    if (gnt0_s) begin
      mem_a  = m0_addr;
      mem_we = m0_we;
      mem_wd = m0_wdata;
    end else if (gnt1_s) begin
      mem_a  = m1_addr;
      mem_we = m1_we;
      mem_wd = m1_wdata;
    end else begin
      mem_a  = '0;
      mem_we = 1'b0;
      mem_wd = '0;
    end
  end

  assign m0_gnt = gnt0_s;
  assign m1_gnt = gnt1_s;

  dmem_resp_reg #(.DW(DW)) u_resp0 (
    .clk_i    (CLK),
    .rst_i    (RST),
    .rd_en_i  (gnt0_s & ~m0_we),
    .rdata_i  (mem_rd),
    .rvalid_o (m0_rvalid),
    .rdata_o  (m0_rdata)
  );

  dmem_resp_reg #(.DW(DW)) u_resp1 (
    .clk_i    (CLK),
    .rst_i    (RST),
    .rd_en_i  (gnt1_s & ~m1_we),
    .rdata_i  (mem_rd),
    .rvalid_o (m1_rvalid),
    .rdata_o  (m1_rdata)
  );

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall0_q, stall1_q;

  // Saturating count of cycles a port requested but was not granted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall0_q <= 16'd0;
      stall1_q <= 16'd0;
    end else begin
      if (m0_req && !gnt0_s && (stall0_q != 16'hFFFF)) begin
        stall0_q <= stall0_q + 16'd1;
      end else begin
        stall0_q <= stall0_q;
      end
      if (m1_req && !gnt1_s && (stall1_q != 16'hFFFF)) begin
        stall1_q <= stall1_q + 16'd1;
      end else begin
        stall1_q <= stall1_q;
      end
    end
  end

  assign stall0_cnt = stall0_q;
  assign stall1_cnt = stall1_q;
`endif

endmodule
